// File: rtl/rom_shadow_loader.sv
// rom_shadow_loader: boot-time copier from the on-chip boot ROM into SRAM.
// After a start pulse it walks ROM addresses 0..ROM_WORDS-1 and writes each byte
// to SRAM through a req/ack write port. It holds the CPU off the bus until the
// copy finishes. Each byte takes three states: READ presents the address, LATCH
// captures the registered ROM data, and WRITE holds the request until it is
// acknowledged.
// Optional feature: define ROM_SHADOW_CHECKSUM_EN to add a 16-bit running sum of
// the bytes written (output port checksum).
module rom_shadow_loader #(
  parameter int unsigned ROM_WORDS = 9216,
  parameter logic [20:0] DEST_BASE = 21'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [13:0] rom_a,
  input  logic [7:0]  rom_dout,
  output logic [20:0] sram_a,
  output logic [7:0]  sram_dout,
  output logic        sram_we,
  output logic        sram_req,
  input  logic        sram_ack,
  output logic        busy,
  output logic        done,
  output logic        cpu_hold
`ifdef ROM_SHADOW_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Index of the last byte; 14 bits covers ROM_WORDS up to 16384 without overflow.
  localparam logic [13:0] LAST_INDEX = 14'(ROM_WORDS - 1);

  state_t      state_r;
  logic [13:0] index_r;

  // Copy sequencer: state, byte index and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      index_r   <= 14'd0;
      rom_a     <= 14'd0;
      sram_a    <= DEST_BASE;
      sram_dout <= 8'd0;
      sram_req  <= 1'b0;
      sram_we   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_hold  <= 1'b1;
`ifdef ROM_SHADOW_CHECKSUM_EN
      checksum  <= 16'd0;
`endif
    end else begin
      case (state_r)
        // Idle or finished: a start pulse (re)starts the copy from byte 0.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r  <= ST_READ;
            busy     <= 1'b1;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
            index_r  <= 14'd0;
            rom_a    <= 14'd0;
`ifdef ROM_SHADOW_CHECKSUM_EN
            checksum <= 16'd0;
`endif
          end
        end
        // ROM address is presented; the registered data arrives next cycle.
        ST_READ: begin
          state_r <= ST_LATCH;
        end
        // ROM data is valid now: capture it and raise the write request.
        ST_LATCH: begin
          sram_dout <= rom_dout;
          sram_a    <= DEST_BASE + {7'd0, index_r};
          sram_req  <= 1'b1;
          sram_we   <= 1'b1;
          state_r   <= ST_WRITE;
        end
        // Hold request, address and data stable until the arbiter accepts.
        ST_WRITE: begin
          if (sram_ack) begin
            sram_req <= 1'b0;
            sram_we  <= 1'b0;
`ifdef ROM_SHADOW_CHECKSUM_EN
            checksum <= checksum + {8'd0, sram_dout};
`endif
            if (index_r == LAST_INDEX) begin
              state_r  <= ST_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              index_r <= index_r + 14'd1;
              rom_a   <= index_r + 14'd1;
              state_r <= ST_READ;
            end
          end
        end
        // An unreachable encoding drops the request and returns to idle.
        default: begin
          state_r  <= ST_IDLE;
          sram_req <= 1'b0;
          sram_we  <= 1'b0;
          busy     <= 1'b0;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_shadow_loader.sv
// tb_rom_shadow_loader: three loader instances share clk/rst/start and one ack
// delay setting. Instance 0 copies 4 bytes to 010000, instance 1 copies 4 bytes
// to 1FFFFE (address wrap), and instance 2 copies FF,FF,02 (checksum case).
// Expected writes are queued when a copy is started. They are popped as each
// accepted write is observed.
module tb_rom_shadow_loader;

  localparam int NI = 3;
  localparam int WORDS [NI] = '{4, 4, 3};
  localparam logic [20:0] BASES [NI] = '{21'h010000, 21'h1FFFFE, 21'h000100};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] rom_a     [NI];
  logic [7:0]  rom_dout  [NI];
  logic [20:0] sram_a    [NI];
  logic [7:0]  sram_dout [NI];
  logic [NI-1:0] sram_we, sram_req, sram_ack, busy, done, cpu_hold;
`ifdef ROM_SHADOW_CHECKSUM_EN
  logic [15:0] csum [NI];
  localparam logic [15:0] EXP_CSUM [NI] = '{16'h00AA, 16'h00AA, 16'h0200};
`endif

  logic [7:0]  rom_mem [NI][4];
  int          dly = 0;
  int          wcnt [NI];
  logic [31:0] exp_q [NI][$];
  logic [31:0] hold_val [NI];
  logic        hold_prev [NI];
  logic        done_prev [NI];
  int          done_rise [NI];
  int          rise_base [NI];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  rom_shadow_loader #(.ROM_WORDS(4), .DEST_BASE(21'h010000)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .rom_a(rom_a[0]), .rom_dout(rom_dout[0]),
    .sram_a(sram_a[0]), .sram_dout(sram_dout[0]), .sram_we(sram_we[0]),
    .sram_req(sram_req[0]), .sram_ack(sram_ack[0]), .busy(busy[0]), .done(done[0]),
    .cpu_hold(cpu_hold[0])
`ifdef ROM_SHADOW_CHECKSUM_EN
    , .checksum(csum[0])
`endif
  );

  rom_shadow_loader #(.ROM_WORDS(4), .DEST_BASE(21'h1FFFFE)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .rom_a(rom_a[1]), .rom_dout(rom_dout[1]),
    .sram_a(sram_a[1]), .sram_dout(sram_dout[1]), .sram_we(sram_we[1]),
    .sram_req(sram_req[1]), .sram_ack(sram_ack[1]), .busy(busy[1]), .done(done[1]),
    .cpu_hold(cpu_hold[1])
`ifdef ROM_SHADOW_CHECKSUM_EN
    , .checksum(csum[1])
`endif
  );

  rom_shadow_loader #(.ROM_WORDS(3), .DEST_BASE(21'h000100)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .rom_a(rom_a[2]), .rom_dout(rom_dout[2]),
    .sram_a(sram_a[2]), .sram_dout(sram_dout[2]), .sram_we(sram_we[2]),
    .sram_req(sram_req[2]), .sram_ack(sram_ack[2]), .busy(busy[2]), .done(done[2]),
    .cpu_hold(cpu_hold[2])
`ifdef ROM_SHADOW_CHECKSUM_EN
    , .checksum(csum[2])
`endif
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ROM model: synchronous BRAM with one cycle of read latency.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) rom_dout[i] <= rom_mem[i][rom_a[i][1:0]];
  end

  // Ack model: tied high when dly==0, otherwise asserted after dly waiting cycles.
  always_comb begin
    for (int i = 0; i < NI; i++) begin
      sram_ack[i] = (dly == 0) ? 1'b1 : (sram_req[i] && (wcnt[i] == dly));
    end
  end

  // Counts how long each request has been waiting for an ack.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!sram_req[i]) wcnt[i] <= 0;
      else if (!sram_ack[i]) wcnt[i] <= wcnt[i] + 1;
    end
  end

  // Monitor: scores accepted writes, checks that a waiting request is stable,
  // and counts rising edges of done.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        check_eq($sformatf("we_eq_req%0d", i), {31'd0, sram_we[i]}, {31'd0, sram_req[i]});
        if (done[i] && !done_prev[i]) done_rise[i] <= done_rise[i] + 1;
        if (sram_req[i]) begin
          if (hold_prev[i])
            check_eq($sformatf("stable%0d", i), {3'd0, sram_a[i], sram_dout[i]}, hold_val[i]);
          if (sram_ack[i]) begin
            check_eq($sformatf("write%0d", i), {3'd0, sram_a[i], sram_dout[i]},
                     (exp_q[i].size() > 0) ? exp_q[i].pop_front() : 32'hDEADBEEF);
            hold_prev[i] <= 1'b0;
          end else begin
            hold_prev[i] <= 1'b1;
            hold_val[i]  <= {3'd0, sram_a[i], sram_dout[i]};
          end
        end else begin
          hold_prev[i] <= 1'b0;
        end
      end else begin
        hold_prev[i] <= 1'b0;
      end
      done_prev[i] <= done[i];
    end
  end

  // Checks every instance for its reset values.
  task automatic check_reset(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s_rom_a%0d", tag, i), {18'd0, rom_a[i]}, 32'd0);
      check_eq($sformatf("%s_sram_a%0d", tag, i), {11'd0, sram_a[i]}, {11'd0, BASES[i]});
      check_eq($sformatf("%s_dout%0d", tag, i), {24'd0, sram_dout[i]}, 32'd0);
      check_eq($sformatf("%s_req%0d", tag, i), {31'd0, sram_req[i]}, 32'd0);
      check_eq($sformatf("%s_busy%0d", tag, i), {31'd0, busy[i]}, 32'd0);
      check_eq($sformatf("%s_done%0d", tag, i), {31'd0, done[i]}, 32'd0);
      check_eq($sformatf("%s_hold%0d", tag, i), {31'd0, cpu_hold[i]}, 32'd1);
`ifdef ROM_SHADOW_CHECKSUM_EN
      check_eq($sformatf("%s_csum%0d", tag, i), {16'd0, csum[i]}, 32'd0);
`endif
    end
  endtask

  // Queues the expected writes and pulses start. On return it is the negedge
  // right after the edge that sampled start.
  task automatic start_copy();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < WORDS[i]; k++)
        exp_q[i].push_back({3'd0, 21'(BASES[i] + 21'(k)), rom_mem[i][k]});
      rise_base[i] = done_rise[i];
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("st_busy%0d", i), {31'd0, busy[i]}, 32'd1);
      check_eq($sformatf("st_done%0d", i), {31'd0, done[i]}, 32'd0);
      check_eq($sformatf("st_hold%0d", i), {31'd0, cpu_hold[i]}, 32'd1);
`ifdef ROM_SHADOW_CHECKSUM_EN
      check_eq($sformatf("st_csum%0d", i), {16'd0, csum[i]}, 32'd0);
`endif
    end
  endtask

  // Counts edges from the start edge until done, with an optional extra start
  // pulse sampled at edge intrude_at+1, then checks completion.
  task automatic wait_done(input int intrude_at);
    int first [NI];
    int n;
    logic all_done;
    n = 0;
    all_done = 1'b0;
    for (int i = 0; i < NI; i++) first[i] = 0;
    while (!all_done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == intrude_at);
      all_done = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (done[i] && first[i] == 0) first[i] = n;
        if (first[i] == 0) all_done = 1'b0;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("done_edges%0d", i), first[i], WORDS[i] * (3 + dly));
      check_eq($sformatf("end_hold%0d", i), {31'd0, cpu_hold[i]}, 32'd0);
      check_eq($sformatf("end_busy%0d", i), {31'd0, busy[i]}, 32'd0);
      check_eq($sformatf("end_done%0d", i), {31'd0, done[i]}, 32'd1);
      check_eq($sformatf("done_rises%0d", i), done_rise[i] - rise_base[i], 32'd1);
      check_eq($sformatf("left_writes%0d", i), exp_q[i].size(), 32'd0);
`ifdef ROM_SHADOW_CHECKSUM_EN
      check_eq($sformatf("csum%0d", i), {16'd0, csum[i]}, {16'd0, EXP_CSUM[i]});
`endif
    end
  endtask

  initial begin
    logic found;
    rom_mem[0] = '{8'h11, 8'h22, 8'h33, 8'h44};
    rom_mem[1] = '{8'h11, 8'h22, 8'h33, 8'h44};
    rom_mem[2] = '{8'hFF, 8'hFF, 8'h02, 8'h00};
    for (int i = 0; i < NI; i++) begin
      wcnt[i] = 0;
      done_rise[i] = 0;
      hold_prev[i] = 1'b0;
      done_prev[i] = 1'b0;
    end

    repeat (2) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;

    // Ack tied high: 3 edges per byte.
    dly = 0;
    start_copy();
    wait_done(0);

    // Restart from DONE with ack delayed 3 cycles per write.
    dly = 3;
    start_copy();
    wait_done(0);

    // A start pulse while busy, sampled during byte 2, must be ignored.
    dly = 0;
    start_copy();
    wait_done(7);

    // Reset while byte 1 is waiting in WRITE with req high.
    dly = 3;
    start_copy();
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (sram_req[0] && sram_a[0] == BASES[0] + 21'd1) found = 1'b1;
    end
    check_eq("abort_reached", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("abort");
    rst = 1'b0;
    for (int i = 0; i < NI; i++) exp_q[i].delete();

    // A fresh copy after the abort starts again at byte 0.
    dly = 0;
    start_copy();
    wait_done(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_shadow_loader.md
Name: rom_shadow_loader

Overview:
- Boot-time sequencer for the on-chip boot/DivMMC ROM, a 14-bit-address, 8-bit synchronous BRAM with 1-cycle registered read latency.
- On a start pulse, it walks the ROM from address 0 to ROM_WORDS-1 and copies each byte into external SRAM through a req/ack write port.
- Holds the CPU off the bus via cpu_hold until the copy completes.
- Sits between the ROM, the SRAM arbiter and the CPU reset/wait logic.

Parameters:
ROM_WORDS, 9216, number of bytes copied; legal range 1..16384
DEST_BASE, 21'h000000, SRAM byte address receiving ROM byte 0

Ports:
clk        in   1   system clock
rst        in   1   synchronous, active-high reset
start      in   1   1-cycle pulse; begins a copy
rom_a      out  14  ROM read address
rom_dout   in   8   ROM data, valid the cycle after rom_a is presented
sram_a     out  21  SRAM write address
sram_dout  out  8   SRAM write data
sram_we    out  1   write enable; always equals sram_req
sram_req   out  1   write request, held until acknowledged
sram_ack   in   1   arbiter accepts the write on a cycle where req=1 and ack=1
busy       out  1   copy in progress
done       out  1   copy completed; sticky until the next start or rst
cpu_hold   out  1   1 = CPU held in wait/reset

Behaviour:
- Reset values: rom_a=0, sram_a=DEST_BASE, sram_dout=0, sram_req=0, sram_we=0, busy=0, done=0, cpu_hold=1. The internal index is also cleared to 0.
- All outputs are registered.
- FSM states: IDLE, READ, LATCH, WRITE, DONE.
- IDLE: when start=1, go to READ. Set busy<=1, done<=0, cpu_hold<=1, index<=0, rom_a<=0.
- READ: rom_a holds the index. Go to LATCH.
- LATCH: rom_dout is valid this cycle. Register sram_dout<=rom_dout, sram_a<=(DEST_BASE+index) mod 2^21, sram_req<=1. Go to WRITE.
- WRITE: sram_req, sram_a and sram_dout stay stable until ack. When sram_ack=1 is sampled, sram_req<=0 on the same edge.
  - If index==ROM_WORDS-1: go to DONE, set busy<=0, done<=1, cpu_hold<=0.
  - Otherwise: index<=index+1, rom_a<=index+1, go to READ.
- sram_ack while sram_req=0 is ignored.
- DONE: when start=1, restart exactly as from IDLE; cpu_hold reasserts on the following cycle.
- start while busy is ignored and has no effect.
- Throughput with ack tied high: 3 cycles per byte. done rises 3*ROM_WORDS clock edges after the edge that sampled start.
- Destination address wraps modulo 2^21 and raises no error.
- The index counter is 14 bits. ROM_WORDS=16384 terminates at index 16383 with no overflow.
- rst at any time, including mid-write with sram_req high, aborts the copy. All outputs return to reset values on the next edge and the FSM returns to IDLE. A partially written SRAM image is permitted.
- rst has priority over start in the same cycle.

Optional Feature:
- Macro: ROM_SHADOW_CHECKSUM_EN.
- Enabled:
  - Extra output port checksum (out, 16 bits).
  - Cleared to 0 on rst and on an accepted start.
  - On each accepted write (WRITE with ack=1), checksum <= checksum + zero-extended sram_dout, wrapping mod 2^16.
  - Final value is stable when done=1.
- Disabled: the port and its adder are absent; all other behaviour is identical.

Test Plan:
- ROM_WORDS=4, ROM bytes 11,22,33,44, DEST_BASE=21'h010000, ack tied 1, pulse start:
  - writes 11@010000, 22@010001, 33@010002, 44@010003;
  - done=1 and cpu_hold=0 exactly 12 edges after start sampled.
- Same setup, ack delayed 3 cycles per write:
  - sram_req, sram_a and sram_dout stay stable through the wait;
  - exactly 4 writes, no duplicates;
  - done 24 edges after start.
- Start pulsed again while busy at byte 2: ignored; byte sequence unchanged, single done edge.
- rst asserted in WRITE with req=1 during byte 1: next edge gives sram_req=0, busy=0, done=0, cpu_hold=1, rom_a=0. A new start copies from byte 0.
- DEST_BASE=21'h1FFFFE, ROM_WORDS=4: write addresses 1FFFFE, 1FFFFF, 000000, 000001.
- ROM_SHADOW_CHECKSUM_EN defined, ROM_WORDS=3, bytes FF,FF,02: checksum=16'h0200 at done. A restart clears it to 0 the cycle after start.
